ahb_button_bank: RTL and testbench

Parametrised AHB-Lite slave that debounces NUM_BUTTONS active-low push-button inputs and classifies each press as short or long. It latches per-button event flags (write-1-to-clear) and raises a maskable level interrupt. It sits on the cycle-computer AHB bus beside the display and timer slaves and replaces fixed two-button polling with a scalable, interrupt-capable button interface.

---
 rtl/ahb_button_pkg.sv | 19 +
 rtl/button_channel.sv | 96 +++++++++
 rtl/ahb_button_bank.sv | 107 ++++++++++
 tb/tb_ahb_button_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_button_pkg.sv
// Shared constants and types for the AHB button bank: register offsets,
// bus encodings and the per-channel press-classification states.
package ahb_button_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_PRESS  = 2'd1;
  localparam logic [1:0] REG_LONG   = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG_HELD
  } btn_state_t;

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, restartable debounce counter and a
// short/long press classifier emitting single-cycle event pulses.
module button_channel
  import ahb_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 670,
  parameter int unsigned LONG_CYCLES     = 30000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic nButton,
  output logic level,
  output logic press_pulse,
  output logic long_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic             sync1, sync2;
  logic             pressed_raw;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  btn_state_t       state, state_nxt;

  assign pressed_raw = ~sync2;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= nButton;
      sync2 <= sync1;
    end
  end

  // Any cycle where the input agrees with the accepted level restarts the count.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      deb_cnt <= '0;
      level   <= 1'b0;
    end else if (pressed_raw != level) begin
      if (deb_cnt == DEB_LAST) begin
        deb_cnt <= '0;
        level   <= ~level;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    press_pulse  = 1'b0;
    long_pulse   = 1'b0;
    case (state)
      IDLE: begin
        if (level) begin
          state_nxt    = PRESSED;
          hold_cnt_nxt = '0;
        end
      end
      PRESSED: begin
        if (!level) begin
          state_nxt   = IDLE;
          press_pulse = 1'b1;
        end else if (hold_cnt == LONG_LAST) begin
          state_nxt  = LONG_HELD;
          long_pulse = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!level) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_button_bank.sv
// AHB-Lite slave exposing debounced button levels, W1C short/long press
// flags and a maskable, registered level interrupt.
module ahb_button_bank
  import ahb_button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 670,
  parameter int unsigned LONG_CYCLES     = 30000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [31:0]            HADDR,
  input  logic [31:0]            HWDATA,
  input  logic [2:0]             HSIZE,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic                   HREADY,
  input  logic                   HSEL,
  output logic [31:0]            HRDATA,
  output logic                   HREADYOUT,
  input  logic [NUM_BUTTONS-1:0] nButton,
  output logic                   IRQ
);

  localparam int unsigned N = NUM_BUTTONS;

  logic [N-1:0] level, press_pulse, long_pulse;
  logic [N-1:0] press_flag, long_flag, en_p, en_l;
  logic         dp_valid, dp_write, dp_word;
  logic [1:0]   dp_addr;
  logic         wr_act, wr_press, wr_long, wr_en;
  logic         unused_bits;

  for (genvar i = 0; i < N; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .nButton    (nButton[i]),
      .level      (level[i]),
      .press_pulse(press_pulse[i]),
      .long_pulse (long_pulse[i])
    );
  end

  assign HREADYOUT   = 1'b1;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_word  <= 1'b0;
      dp_addr  <= '0;
    end else if (HREADY) begin
      dp_valid <= HSEL && (HTRANS != HTRANS_IDLE);
      dp_write <= HWRITE;
      dp_word  <= (HSIZE == HSIZE_WORD);
      dp_addr  <= HADDR[3:2];
    end
  end

  assign wr_act   = dp_valid && dp_write && dp_word;
  assign wr_press = wr_act && (dp_addr == REG_PRESS);
  assign wr_long  = wr_act && (dp_addr == REG_LONG);
  assign wr_en    = wr_act && (dp_addr == REG_IRQ_EN);

  // New events are OR-ed in after the clear so a coincident set survives.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      press_flag <= '0;
      long_flag  <= '0;
      en_p       <= '0;
      en_l       <= '0;
      IRQ        <= 1'b0;
    end else begin
      press_flag <= (press_flag & ~(wr_press ? HWDATA[N-1:0] : '0)) | press_pulse;
      long_flag  <= (long_flag  & ~(wr_long  ? HWDATA[N-1:0] : '0)) | long_pulse;
      if (wr_en) begin
        en_p <= HWDATA[N-1:0];
        en_l <= HWDATA[N+15:16];
      end
      IRQ <= (|(press_flag & en_p)) | (|(long_flag & en_l));
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid && !dp_write) begin
      case (dp_addr)
        REG_STATUS: HRDATA[N-1:0] = level;
        REG_PRESS:  HRDATA[N-1:0] = press_flag;
        REG_LONG:   HRDATA[N-1:0] = long_flag;
        REG_IRQ_EN: begin
          HRDATA[N-1:0]   = en_p;
          HRDATA[N+15:16] = en_l;
        end
        default: HRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_button_bank.sv
// Directed bench for ahb_button_bank: register table, debounce, glitch,
// long press, interrupt masking, set-vs-clear collision and mid-press reset.
module tb_ahb_button_bank;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HSEL, HREADYOUT, IRQ;
  logic [3:0]  nButton;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 HCLK = ~HCLK;

  ahb_button_bank #(
    .NUM_BUTTONS    (4),
    .DEBOUNCE_CYCLES(670),
    .LONG_CYCLES    (30000),
    .CNT_W          (20)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HSIZE    (HSIZE),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HREADY   (HREADY),
    .HSEL     (HSEL),
    .HRDATA   (HRDATA),
    .HREADYOUT(HREADYOUT),
    .nButton  (nButton),
    .IRQ      (IRQ)
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  idx;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Address phase, then data phase; returns one tick after the write edge.
  task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010;
    HADDR = {28'h0, idx, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  // Returns during the data phase, so reads can be issued back to back.
  task automatic bus_read(input logic [1:0] idx, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010;
    HADDR = {28'h0, idx, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic read_check(input string name, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(idx, d);
    check(name, d, exp);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int unsigned n;
    logic found;

    HRESETn = 1'b0; HADDR = '0; HWDATA = '0; HSIZE = 3'b010; HTRANS = 2'b00;
    HWRITE = 1'b0; HREADY = 1'b1; HSEL = 1'b0; nButton = 4'hF;

    vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
    vecs[5]  = '{1'b0, 2'd3, 32'h0,        32'h000F_000F};
    vecs[6]  = '{1'b1, 2'd0, 32'h0000_000F, 32'h0};
    vecs[7]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 2'd1, 32'h0000_000F, 32'h0};
    vecs[9]  = '{1'b0, 2'd1, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 2'd3, 32'h0000_0000, 32'h0};
    vecs[11] = '{1'b0, 2'd3, 32'h0,        32'h0};

    cycles(3);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    HRESETn = 1'b1;
    cycles(2);
    check("hreadyout", {31'h0, HREADYOUT}, 32'h1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].idx, vecs[i].data);
      else read_check($sformatf("vec%0d", i), vecs[i].idx, vecs[i].exp);
    end
    cycles(1);

    // Short press on button 0: level appears exactly 672 edges after the pin edge
    nButton[0] = 1'b0;
    cycles(670);
    read_check("status_671", 2'd0, 32'h0);
    read_check("status_672", 2'd0, 32'h1);
    cycles(328);
    nButton[0] = 1'b1;
    cycles(800);
    read_check("short_press", 2'd1, 32'h1);
    read_check("short_long", 2'd2, 32'h0);
    check("short_irq_masked", {31'h0, IRQ}, 32'h0);
    bus_write(2'd1, 32'h1);
    read_check("press_w1c", 2'd1, 32'h0);

    // Glitches on button 2 shorter than the debounce window
    for (int g = 0; g < 5; g++) begin
      nButton[2] = 1'b0;
      cycles(300);
      nButton[2] = 1'b1;
      cycles(10);
    end
    read_check("glitch_status", 2'd0, 32'h0);
    cycles(700);
    read_check("glitch_press", 2'd1, 32'h0);
    read_check("glitch_long", 2'd2, 32'h0);

    // Interrupt: PRESS bit0 and LONG bit0 enabled
    bus_write(2'd3, 32'h0001_0001);
    read_check("irq_en_rb", 2'd3, 32'h0001_0001);
    nButton[0] = 1'b0;
    cycles(1000);
    nButton[0] = 1'b1;
    found = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      bus_read(2'd1, d);
      if (d[0]) begin found = 1'b1; break; end
    end
    check("irq_flag_seen", {31'h0, found}, 32'h1);
    check("irq_lags_flag", {31'h0, IRQ}, 32'h0);
    cycles(1);
    check("irq_set", {31'h0, IRQ}, 32'h1);
    bus_write(2'd1, 32'h1);
    check("irq_hold_after_clr", {31'h0, IRQ}, 32'h1);
    cycles(1);
    check("irq_clr", {31'h0, IRQ}, 32'h0);

    // Long press on button 1 (its LONG enable is off)
    nButton[1] = 1'b0;
    cycles(35000);
    read_check("long_status", 2'd0, 32'h2);
    read_check("long_held", 2'd2, 32'h2);
    check("long_irq_masked", {31'h0, IRQ}, 32'h0);
    cycles(5000);
    nButton[1] = 1'b1;
    cycles(800);
    read_check("long_no_press", 2'd1, 32'h0);
    read_check("long_after_rel", 2'd2, 32'h2);
    check("long_irq_after", {31'h0, IRQ}, 32'h0);
    bus_write(2'd2, 32'h2);
    read_check("long_w1c", 2'd2, 32'h0);

    // Measure release-to-flag latency on button 3, then collide a W1C with it
    nButton[3] = 1'b0;
    cycles(1000);
    nButton[3] = 1'b1;
    found = 1'b0;
    n = 0;
    for (int k = 1; k <= 2000; k++) begin
      bus_read(2'd1, d);
      if (d[3]) begin found = 1'b1; n = k; break; end
    end
    check("b3_flag_seen", {31'h0, found}, 32'h1);
    bus_write(2'd1, 32'h8);
    read_check("b3_clear", 2'd1, 32'h0);
    cycles(2);
    if (found && n >= 3) begin
      nButton[3] = 1'b0;
      cycles(1000);
      nButton[3] = 1'b1;
      cycles(n - 2);
      bus_write(2'd1, 32'h8);
      read_check("set_beats_clear", 2'd1, 32'h8);
    end else begin
      check("collide_latency", n, 32'd673);
    end
    bus_write(2'd1, 32'hF);
    bus_write(2'd3, 32'h0);

    // Reset while button 2 is held; release during reset
    nButton[2] = 1'b0;
    cycles(1000);
    HRESETn = 1'b0;
    #3;
    nButton[2] = 1'b1;
    cycles(2);
    HRESETn = 1'b1;
    cycles(1000);
    read_check("rst_mid_status", 2'd0, 32'h0);
    read_check("rst_mid_press", 2'd1, 32'h0);
    read_check("rst_mid_long", 2'd2, 32'h0);
    check("rst_mid_irq", {31'h0, IRQ}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
